btn_debounce_ctrl: RTL and testbench

- Parametrised N-channel push-button front end for the calculator operator keys (and any future keypad rows).
- Per channel: synchronises the raw pin, debounces it, and produces a clean level, one-cycle press/release pulses, and optional hold-to-repeat pulses.
- A priority encoder condenses simultaneous press events into one one-hot code plus a valid strobe.
- The downstream operator FSM consumes single-cycle events instead of polling levels.

---
 rtl/btn_pkg.sv | 29 ++
 rtl/btn_debounce_chan.sv | 131 +++++++++++++
 rtl/btn_debounce_ctrl.sv | 101 ++++++++++
 tb/tb_btn_debounce_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end.
// Default constants assume a 50 MHz system clock.
package btn_pkg;

   localparam int CLK_HZ           = 50_000_000;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms
   localparam int DEF_REPEAT_DLY   = 25_000_000;  // 500 ms
   localparam int DEF_REPEAT_RATE  = 5_000_000;   // 100 ms
   localparam int DEF_CNT_W        = 25;

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_REPEAT   = 2'd2
   } chan_state_e;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: input synchroniser, debounce FSM and hold-to-repeat timer.
// Outputs are registered single-cycle pulses plus the accepted level.
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic rel
);

   localparam logic [1:0] S_RELEASED = 2'(ST_RELEASED);
   localparam logic [1:0] S_PRESSED  = 2'(ST_PRESSED);
   localparam logic [1:0] S_REPEAT   = 2'(ST_REPEAT);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] rcnt_reg, rcnt_next;
   logic [CNT_W-1:0] hold_last;
   logic             level_reg, level_next;
   logic             press_reg, press_next;
   logic             rel_reg, rel_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign s = sync_reg[SYNC_STAGES-1];

   assign hold_last = (state_reg == S_REPEAT) ? RATE_LAST : DLY_LAST;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rcnt_next  = rcnt_reg;
      level_next = level_reg;
      press_next = 1'b0;
      rel_next   = 1'b0;
      case (state_reg)
         S_RELEASED: begin
            rcnt_next = '0;
            if (!s) begin
               cnt_next = '0;
            end else if (cnt_reg == DEB_LAST) begin
               state_next = S_PRESSED;
               level_next = 1'b1;
               press_next = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_PRESSED, S_REPEAT: begin
            if (s) begin
               cnt_next = '0;
            end else if (cnt_reg == DEB_LAST) begin
               state_next = S_RELEASED;
               level_next = 1'b0;
               rel_next   = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
            // Repeat timer only advances on clean high samples, so a bouncing release freezes it.
            if (!repeat_en) begin
               rcnt_next = '0;
               if (state_next == S_REPEAT) begin
                  state_next = S_PRESSED;
               end
            end else if (s) begin
               if (rcnt_reg == hold_last) begin
                  press_next = 1'b1;
                  rcnt_next  = '0;
                  state_next = S_REPEAT;
               end else begin
                  rcnt_next = rcnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = S_RELEASED;
            cnt_next   = '0;
            rcnt_next  = '0;
            level_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_RELEASED;
         cnt_reg   <= '0;
         rcnt_reg  <= '0;
         level_reg <= 1'b0;
         press_reg <= 1'b0;
         rel_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rcnt_reg  <= rcnt_next;
         level_reg <= level_next;
         press_reg <= press_next;
         rel_reg   <= rel_next;
      end
   end

   assign level = level_reg;
   assign press = press_reg;
   assign rel   = rel_reg;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// N-channel button front end: per-channel debounce plus a registered
// highest-index-wins press encoder for the operator FSM.
module btn_debounce_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN        = 4,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_i,
   input  logic             repeat_en,
   output logic [N_BTN-1:0] btn_level_o,
   output logic [N_BTN-1:0] btn_press_o,
   output logic [N_BTN-1:0] btn_release_o,
   output logic [N_BTN-1:0] btn_code_o,
   output logic             code_valid_o
);

   localparam int MAX_CNT = max3(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_RATE);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_err_sync
      $fatal(1, "btn_debounce_ctrl: SYNC_STAGES must be 2..4");
   end
   if (DEBOUNCE_CYC < 2) begin : g_err_deb
      $fatal(1, "btn_debounce_ctrl: DEBOUNCE_CYC must be >= 2");
   end
   if (REPEAT_RATE < 1 || REPEAT_DLY < 1) begin : g_err_rep
      $fatal(1, "btn_debounce_ctrl: REPEAT_RATE and REPEAT_DLY must be >= 1");
   end
   if (CNT_W < cnt_width(MAX_CNT)) begin : g_err_cnt
      $fatal(1, "btn_debounce_ctrl: CNT_W too small for timing constants");
   end

   logic [N_BTN-1:0] chan_level;
   logic [N_BTN-1:0] chan_press;
   logic [N_BTN-1:0] chan_rel;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_chan
         btn_debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W)
         ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .btn_raw  (btn_i[gi]),
            .repeat_en(repeat_en),
            .level    (chan_level[gi]),
            .press    (chan_press[gi]),
            .rel      (chan_rel[gi])
         );
      end
   endgenerate

   // Ascending scan lets the highest-index press overwrite lower ones.
   logic [N_BTN-1:0] code_next;
   always_comb begin
      code_next = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (chan_press[i]) begin
            code_next    = '0;
            code_next[i] = 1'b1;
         end
      end
   end

   logic [N_BTN-1:0] level_reg, press_reg, rel_reg, code_reg;
   logic             valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_reg <= '0;
         press_reg <= '0;
         rel_reg   <= '0;
         code_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         level_reg <= chan_level;
         press_reg <= chan_press;
         rel_reg   <= chan_rel;
         code_reg  <= code_next;
         valid_reg <= |code_next;
      end
   end

   assign btn_level_o   = level_reg;
   assign btn_press_o   = press_reg;
   assign btn_release_o = rel_reg;
   assign btn_code_o    = code_reg;
   assign code_valid_o  = valid_reg;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl with an expected-event scoreboard
// checked against every output on every cycle.
module tb_btn_debounce_ctrl;

   localparam int LAT = 1 + 2 + 8;  // drive-to-output cycles: 1 + SYNC_STAGES + DEBOUNCE_CYC

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_i;
   logic       repeat_en;
   logic [3:0] btn_level_o, btn_press_o, btn_release_o, btn_code_o;
   logic       code_valid_o;

   btn_debounce_ctrl #(
      .N_BTN       (4),
      .SYNC_STAGES (2),
      .DEBOUNCE_CYC(8),
      .REPEAT_DLY  (20),
      .REPEAT_RATE (5),
      .CNT_W       (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_i        (btn_i),
      .repeat_en    (repeat_en),
      .btn_level_o  (btn_level_o),
      .btn_press_o  (btn_press_o),
      .btn_release_o(btn_release_o),
      .btn_code_o   (btn_code_o),
      .code_valid_o (code_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] code;
      logic       valid;
      logic [3:0] level;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_level = 4'b0000;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      ev_t        e;
      logic [3:0] ep, er, ec;
      logic       ev;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      ep = '0; er = '0; ec = '0; ev = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         ep = e.press; er = e.rel; ec = e.code; ev = e.valid;
         exp_level = e.level;
         $display("event cyc=%0d press=%b rel=%b code=%b valid=%b level=%b",
                  cyc, btn_press_o, btn_release_o, btn_code_o, code_valid_o, btn_level_o);
      end
      check("level", btn_level_o, exp_level);
      check("press", btn_press_o, ep);
      check("release", btn_release_o, er);
      check("code", btn_code_o, ec);
      check("valid", {3'b000, code_valid_o}, {3'b000, ev});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input int dly, input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] c, input logic v, input logic [3:0] l);
      ev_t e;
      e.cyc = cyc + dly; e.press = p; e.rel = r; e.code = c; e.valid = v; e.level = l;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; btn_i = 4'b0000; repeat_en = 1'b0;
      run(3);
      rst = 1'b0;
      run(5);

      // 1: clean press of channel 1, no repeat
      btn_i = 4'b0010;
      push(LAT, 4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010);
      run(40);
      // 3: release of channel 1
      btn_i = 4'b0000;
      push(LAT, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0000);
      run(20);

      // 2: bounce on channel 0, never stable for 8 samples
      for (int i = 0; i < 10; i++) begin
         btn_i = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         run(3);
      end
      btn_i = 4'b0000;
      run(20);

      // 4: simultaneous press on channels 3 and 0
      btn_i = 4'b1001;
      push(LAT, 4'b1001, 4'b0000, 4'b1000, 1'b1, 4'b1001);
      run(20);
      btn_i = 4'b0000;
      push(LAT, 4'b0000, 4'b1001, 4'b0000, 1'b0, 4'b0000);
      run(20);

      // 5: auto-repeat on channel 2: t0, t0+20, +25, +30, +35, then repeat_en drops
      repeat_en = 1'b1;
      btn_i = 4'b0100;
      push(LAT,      4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100);
      push(LAT + 20, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100);
      push(LAT + 25, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100);
      push(LAT + 30, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100);
      push(LAT + 35, 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100);
      run(48);
      repeat_en = 1'b0;
      run(12);
      btn_i = 4'b0000;
      push(LAT, 4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000);
      run(20);

      // 6: reset while channel 3 is mid-debounce (cnt=5)
      btn_i = 4'b1000;
      run(7);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      push(LAT, 4'b1000, 4'b0000, 4'b1000, 1'b1, 4'b1000);
      run(20);
      btn_i = 4'b0000;
      push(LAT, 4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b0000);
      run(20);

      checks++;
      assert (exp_q.size() == 0)
      else begin
         errors++;
         $error("FAIL pending_events got=%0d exp=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
